// File: rtl/psram_access_arbiter.sv
// Two-port arbiter in front of the PSRAM controller command port: camera writer vs display reader.
// One burst command is granted at a time and the port stays owned for the controller's TCMD cycles.
module psram_access_arbiter #(
  parameter int ADDR_WIDTH    = 21,
  parameter int DATA_WIDTH    = 32,
  parameter int TCMD          = 19,
  parameter int READ_PRIORITY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  calib_done,
  input  logic                  wr_rq,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_rq,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic                  rd_data_valid,
  output logic                  mem_cmd,
  output logic                  mem_cmd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_rd_valid,
  output logic                  busy
);

  localparam int CNT_W = (TCMD > 2) ? $clog2(TCMD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TCMD - 1);
  // last_rd_q = 1 means the reader won last; the reset value makes READ_PRIORITY win the first tie.
  localparam logic LAST_RD_RESET = (READ_PRIORITY == 1) ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {
    S_WAIT_CALIB = 2'd0,
    S_ARB        = 2'd1,
    S_BUSY       = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_WRITER = 2'd1,
    OWN_READER = 2'd2
  } owner_t;

  state_t                  state_q;
  owner_t                  owner_q;
  logic                    last_rd_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    busy_q;
  logic                    cmd_en_q;
  logic                    wr_ack_q;
  logic                    rd_ack_q;
  logic                    mem_cmd_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;

  logic                    grant_d;
  logic                    grant_rd_d;

  // Round-robin on a tie: the side that did not win last time goes first.
  always_comb begin
    grant_d    = 1'b0;
    grant_rd_d = 1'b0;
    if (state_q == S_ARB) begin
      grant_d    = wr_rq | rd_rq;
      grant_rd_d = (wr_rq & rd_rq) ? ~last_rd_q : rd_rq;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_WAIT_CALIB;
      owner_q    <= OWN_NONE;
      last_rd_q  <= LAST_RD_RESET;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      cmd_en_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      mem_cmd_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      cmd_en_q <= 1'b0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      case (state_q)
        S_WAIT_CALIB: begin
          if (calib_done) state_q <= S_ARB;
        end
        S_ARB: begin
          if (grant_d) begin
            state_q    <= S_BUSY;
            busy_q     <= 1'b1;
            cmd_en_q   <= 1'b1;
            wr_ack_q   <= ~grant_rd_d;
            rd_ack_q   <= grant_rd_d;
            mem_cmd_q  <= ~grant_rd_d;
            mem_addr_q <= grant_rd_d ? rd_addr : wr_addr;
            owner_q    <= grant_rd_d ? OWN_READER : OWN_WRITER;
            last_rd_q  <= grant_rd_d;
            cnt_q      <= CNT_LOAD;
          end
        end
        S_BUSY: begin
          // The cmd_en cycle plus TCMD-1 further cycles make up one ownership window.
          if (cnt_q == '0) begin
            owner_q <= OWN_NONE;
            busy_q  <= 1'b0;
            state_q <= calib_done ? S_ARB : S_WAIT_CALIB;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_WAIT_CALIB;
        end
      endcase
    end
  end

  assign mem_wr_data   = (owner_q == OWN_WRITER) ? wr_data : '0;
  assign rd_data_valid = (owner_q == OWN_READER) & mem_rd_valid;

  assign wr_ack     = wr_ack_q;
  assign rd_ack     = rd_ack_q;
  assign mem_cmd    = mem_cmd_q;
  assign mem_cmd_en = cmd_en_q;
  assign mem_addr   = mem_addr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_psram_access_arbiter.sv
// Directed scenarios followed by a randomized run, all checked every cycle against a
// timestamp-based model of grants and ownership windows.
module tb_psram_access_arbiter;

  localparam int AW   = 21;
  localparam int DW   = 32;
  localparam int TCMD = 19;
  localparam int RP   = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          calib_done;
  logic          wr_rq;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd_rq;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic          rd_data_valid;
  logic          mem_cmd;
  logic          mem_cmd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_rd_valid;
  logic          busy;

  psram_access_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TCMD(TCMD), .READ_PRIORITY(RP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .calib_done(calib_done),
    .wr_rq(wr_rq), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_rq(rd_rq), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data_valid(rd_data_valid),
    .mem_cmd(mem_cmd), .mem_cmd_en(mem_cmd_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_valid(mem_rd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: a grant at cycle g_cyc owns the port for cycles g_cyc .. g_cyc+TCMD-1.
  bit            m_armed;
  bit            m_have;
  int            g_cyc;
  bit            m_owner_rd;
  bit            m_last_rd;
  logic [AW-1:0] m_addr;
  bit            m_cmd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m_busy();
    return m_have && (cyc >= g_cyc) && ((cyc - g_cyc) < TCMD);
  endfunction

  task automatic model_reset();
    m_armed    = 1'b0;
    m_have     = 1'b0;
    g_cyc      = -1000;
    m_owner_rd = 1'b0;
    m_last_rd  = (RP == 1) ? 1'b0 : 1'b1;
    m_addr     = '0;
    m_cmd      = 1'b0;
  endtask

  // Decide what the upcoming clock edge does, from the inputs presented in the current cycle.
  task automatic model_advance();
    bit rd_wins;
    if (!reset_n) return;
    if (m_busy()) begin
      if ((cyc - g_cyc) == TCMD - 1) m_armed = calib_done;
    end else if (!m_armed) begin
      m_armed = calib_done;
    end else if (wr_rq || rd_rq) begin
      rd_wins    = (wr_rq && rd_rq) ? !m_last_rd : rd_rq;
      m_have     = 1'b1;
      g_cyc      = cyc + 1;
      m_owner_rd = rd_wins;
      m_last_rd  = rd_wins;
      m_addr     = rd_wins ? rd_addr : wr_addr;
      m_cmd      = !rd_wins;
    end
  endtask

  task automatic check_all();
    bit eb, ea;
    eb = m_busy();
    ea = m_have && (cyc == g_cyc);
    chk("busy",        {63'd0, busy},          {63'd0, eb});
    chk("cmd_en",      {63'd0, mem_cmd_en},    {63'd0, ea});
    chk("wr_ack",      {63'd0, wr_ack},        {63'd0, ea && !m_owner_rd});
    chk("rd_ack",      {63'd0, rd_ack},        {63'd0, ea && m_owner_rd});
    chk("mem_cmd",     {63'd0, mem_cmd},       {63'd0, m_cmd});
    chk("mem_addr",    64'(mem_addr),          64'(m_addr));
    chk("mem_wr_data", 64'(mem_wr_data),       (eb && !m_owner_rd) ? 64'(wr_data) : 64'd0);
    chk("rd_valid",    {63'd0, rd_data_valid}, {63'd0, eb && m_owner_rd && mem_rd_valid});
  endtask

  // One clock: model decision, edge, check at the falling edge, then requesters drop on ack.
  task automatic tick();
    model_advance();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_all();
    if (m_have && cyc == g_cyc) begin
      if (m_owner_rd) rd_rq = 1'b0;
      else            wr_rq = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_cmd(input string tag);
    int k;
    k = 0;
    while (!mem_cmd_en && k < 60) begin
      tick();
      k++;
    end
    chk({tag, "_cmd_seen"}, {63'd0, mem_cmd_en}, 64'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    chk("idle_reached", {63'd0, busy}, 64'd0);
    tick();
  endtask

  int n;
  int ng;
  int cnt_en;
  bit got_rd[4];
  int got_cyc[4];

  initial begin
    calib_done   = 1'b0;
    wr_rq        = 1'b0;
    rd_rq        = 1'b0;
    wr_addr      = '0;
    rd_addr      = '0;
    wr_data      = '0;
    mem_rd_valid = 1'b0;
    reset_n      = 1'b0;
    @(negedge clk);
    model_reset();

    // Requests held off while calibration is pending, then granted two cycles after calib_done.
    wr_rq   = 1'b1;
    wr_addr = 21'h01000;
    do_reset();
    cnt_en = 0;
    repeat (50) begin
      tick();
      if (mem_cmd_en || wr_ack) cnt_en++;
    end
    chk("t1_no_cmd_uncal", 64'(cnt_en), 64'd0);
    calib_done = 1'b1;
    tick();
    tick();
    chk("t1_cmd_en",  {63'd0, mem_cmd_en}, 64'd1);
    chk("t1_wr_ack",  {63'd0, wr_ack},     64'd1);
    chk("t1_mem_cmd", {63'd0, mem_cmd},    64'd1);
    chk("t1_addr",    64'(mem_addr),       64'h01000);
    wait_idle();

    // Single read: ownership length and read-valid gating.
    rd_rq   = 1'b1;
    rd_addr = 21'h1F000;
    wait_cmd("t2");
    chk("t2_rd_ack",  {63'd0, rd_ack},  64'd1);
    chk("t2_mem_cmd", {63'd0, mem_cmd}, 64'd0);
    chk("t2_addr",    64'(mem_addr),    64'h1F000);
    n = 0;
    while (busy && n < 100) begin
      n++;
      mem_rd_valid = 1'($urandom_range(0, 1));
      tick();
    end
    chk("t2_busy_len", 64'(n), 64'(TCMD));
    mem_rd_valid = 1'b1;
    repeat (3) tick();
    chk("t2_valid_dropped", {63'd0, rd_data_valid}, 64'd0);
    mem_rd_valid = 1'b0;

    // Simultaneous requests after reset: reader first, then strict alternation.
    do_reset();
    tick();
    rd_rq = 1'b1;
    wr_rq = 1'b1;
    ng = 0;
    for (int k = 0; k < 200 && ng < 4; k++) begin
      tick();
      if (mem_cmd_en) begin
        got_rd[ng]  = rd_ack;
        got_cyc[ng] = cyc;
        ng++;
      end else begin
        if (!wr_rq) wr_rq = 1'b1;
        if (!rd_rq) rd_rq = 1'b1;
      end
    end
    chk("t3_grants", 64'(ng), 64'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t3_order%0d", k), {63'd0, got_rd[k]}, {63'd0, (k % 2) == 0});
    chk("t3_spacing", 64'(got_cyc[1] - got_cyc[0]), 64'(TCMD + 1));
    wr_rq = 1'b0;
    rd_rq = 1'b0;
    wait_idle();
    wait_idle();

    // Writer data routing over the whole ownership window.
    wr_data = 32'hDEADBEEF;
    wr_addr = 21'h00040;
    wr_rq   = 1'b1;
    wait_cmd("t4");
    for (int k = 0; k < TCMD; k++) begin
      chk($sformatf("t4_wdata%0d", k), 64'(mem_wr_data), 64'hDEADBEEF);
      tick();
    end
    chk("t4_busy_off", {63'd0, busy}, 64'd0);
    chk("t4_wdata_arb", 64'(mem_wr_data), 64'd0);
    tick();

    // calib_done drops mid-burst: burst completes, then no grants until it returns.
    rd_rq   = 1'b1;
    rd_addr = 21'h00777;
    wait_cmd("t5");
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 5) calib_done = 1'b0;
      tick();
    end
    chk("t5_busy_len", 64'(n), 64'(TCMD));
    rd_rq  = 1'b1;
    wr_rq  = 1'b1;
    cnt_en = 0;
    repeat (30) begin
      tick();
      if (mem_cmd_en) cnt_en++;
    end
    chk("t5_no_cmd", 64'(cnt_en), 64'd0);
    calib_done = 1'b1;
    wait_cmd("t5_resume");
    wr_rq = 1'b0;
    rd_rq = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a burst.
    rd_rq   = 1'b1;
    rd_addr = 21'h0F0F0;
    wait_cmd("t6");
    repeat (7) tick();
    wr_data      = $urandom;
    mem_rd_valid = 1'b1;
    reset_n      = 1'b0;
    #1;
    chk("t6_busy_async",   {63'd0, busy},          64'd0);
    chk("t6_cmden_async",  {63'd0, mem_cmd_en},    64'd0);
    chk("t6_rvalid_async", {63'd0, rd_data_valid}, 64'd0);
    chk("t6_wdata_async",  64'(mem_wr_data),       64'd0);
    model_reset();
    check_all();
    rd_rq   = 1'b1;
    rd_addr = 21'h0ABCD;
    tick();
    tick();
    reset_n = 1'b1;
    wait_cmd("t6_after");
    chk("t6_rd_ack", {63'd0, rd_ack}, 64'd1);
    chk("t6_addr",   64'(mem_addr),   64'h0ABCD);
    mem_rd_valid = 1'b0;
    wait_idle();

    // Randomized traffic with occasional calibration loss.
    for (int k = 0; k < 3000; k++) begin
      if (!wr_rq && $urandom_range(0, 3) == 0) begin
        wr_rq   = 1'b1;
        wr_addr = AW'($urandom);
      end
      if (!rd_rq && $urandom_range(0, 3) == 0) begin
        rd_rq   = 1'b1;
        rd_addr = AW'($urandom);
      end
      if ($urandom_range(0, 59) == 0) calib_done = ~calib_done;
      wr_data      = $urandom;
      mem_rd_valid = 1'($urandom_range(0, 1));
      tick();
    end
    calib_done = 1'b1;
    wr_rq      = 1'b0;
    rd_rq      = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/psram_access_arbiter.md
Name: psram_access_arbiter

Overview:
- Shares the single PSRAM memory-controller command port between two requesters.
- Writer port: camera-side frame uploader issuing burst writes. Reader port: display-side frame fetcher issuing burst reads.
- Grants one burst command at a time and holds ownership for the controller's fixed command cycle time.
- Routes write data and read-valid only to the current owner.
- Sits between both frame FSMs and the Gowin PSRAM controller.

Parameters:
- ADDR_WIDTH, 21, PSRAM word address width.
- DATA_WIDTH, 32, controller data word width.
- TCMD, 19, cycles one burst command occupies the controller (burst 32), counted from cmd_en.
- READ_PRIORITY, 1, winner of the first simultaneous request after reset (1 = reader, 0 = writer).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- calib_done  in  1  controller calibration complete; no command is issued while low.
- wr_rq  in  1  writer request; level, held until wr_ack.
- wr_addr  in  ADDR_WIDTH  writer burst address, valid while wr_rq.
- wr_data  in  DATA_WIDTH  writer data, sampled by controller during writer ownership.
- wr_ack  out  1  one-cycle grant pulse to the writer.
- rd_rq  in  1  reader request; level, held until rd_ack.
- rd_addr  in  ADDR_WIDTH  reader burst address.
- rd_ack  out  1  one-cycle grant pulse to the reader.
- rd_data_valid  out  1  mem_rd_valid gated to reader ownership.
- mem_cmd  out  1  1 = write, 0 = read.
- mem_cmd_en  out  1  one-cycle command strobe.
- mem_addr  out  ADDR_WIDTH  command address.
- mem_wr_data  out  DATA_WIDTH  wr_data while the writer owns the port, else 0.
- mem_rd_valid  in  1  controller read-data valid.
- busy  out  1  high while any owner holds the port.

Behaviour:
- Reset (asynchronous, immediate, including mid-burst):
  - All outputs 0; state WAIT_CALIB; owner NONE; last_grant = writer if READ_PRIORITY = 1, else reader; counter 0.
- States:
  - WAIT_CALIB: stay while calib_done = 0; go to ARB when it is 1.
  - ARB: owner NONE. Requests are sampled here only.
    - No request: remain in ARB.
    - Only one request: grant it.
    - Both requesting: grant the side that is not last_grant (round-robin).
    - On grant, the next clock edge registers mem_cmd_en = 1, mem_cmd, mem_addr (from the winner's address), the winner's ack = 1, owner, busy = 1 and last_grant; go to BUSY.
  - BUSY:
    - mem_cmd_en and ack return to 0 one cycle after assertion.
    - mem_addr and mem_cmd hold their values.
    - Counter runs so that BUSY lasts TCMD-1 cycles after the cmd_en cycle; ownership totals exactly TCMD cycles.
    - Then owner NONE and busy = 0. Go to ARB if calib_done = 1, else to WAIT_CALIB.
- Latency: request seen in ARB -> cmd_en/ack on the next cycle. Minimum spacing between consecutive cmd_en pulses is TCMD+1 cycles (one ARB cycle between bursts).
- Starvation bound: a requester waits at most one foreign burst (TCMD+1 cycles) once its request is seen in ARB.
- Requesters must drop rq in the cycle after ack. An rq still high when ARB is re-entered is treated as a new request.
- calib_done falling during BUSY does not abort the burst; the block finishes it, then goes to WAIT_CALIB.
- Routing (combinational from owner):
  - mem_wr_data = wr_data when owner is WRITER, else 0.
  - rd_data_valid = mem_rd_valid when owner is READER, else 0.
  - mem_rd_valid outside reader ownership is dropped.
- Address handling: addresses are not modified, added to or wrapped; they pass through as registered at grant.
- rq while calib_done = 0: held pending; no ack until calibration completes.

Test Plan:
- Reset, calib_done = 0, wr_rq = 1 for 50 cycles -> no mem_cmd_en, no wr_ack. Raise calib_done -> wr_ack and mem_cmd_en with mem_cmd = 1 and mem_addr = wr_addr (0x01000) exactly 2 cycles later.
- Single read rd_addr = 0x1F000 -> rd_ack and mem_cmd_en pulse 1 cycle each, mem_cmd = 0, busy high exactly 19 cycles. mem_rd_valid pulses during ownership appear on rd_data_valid; pulses injected after busy falls do not.
- wr_rq and rd_rq rise together after reset with READ_PRIORITY = 1 -> reader granted first, writer's cmd_en exactly 20 cycles after the reader's. Both rising together again -> writer is not granted twice in a row; grant order alternates R,W,R,W across 4 bursts.
- Writer ownership with wr_data = 0xDEADBEEF -> mem_wr_data = 0xDEADBEEF during all 19 owned cycles, 0 in the next ARB cycle.
- calib_done dropped at BUSY cycle 5 -> burst completes (busy still 19 cycles), then no further grants until calib_done returns.
- reset_n asserted at BUSY cycle 8 -> busy, mem_cmd_en, acks and routed data are 0 immediately. After release with calib_done = 1 and a pending rd_rq, the next grant occurs normally.
